dec_stage: RTL and testbench

- Registered, parametrised multi-lane decode stage between fetch and rename/issue.
- Accepts a bundle of up to NB_LANES instructions per cycle.
- Decodes each lane with one decoder instance per lane.
- Presents the decoded micro-ops through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Adds, relative to a bare decoder array, the following:
  - per-lane valid;
  - truncation of the bundle after the first illegal instruction;
  - flush;
  - a back-pressure-tolerant registered output.

---
 rtl/riscv.sv | 60 ++++++
 rtl/dec_skid_buf.sv | 64 ++++++
 rtl/decoder.sv | 95 +++++++++
 rtl/dec_stage.sv | 108 ++++++++++
 tb/tb_dec_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv.sv
// riscv: shared decode types, instr_type one-hot encoding and the front-end width default
// Contents:
//   FRONTEND_WIDTH : default number of decode lanes
//   T_*            : bit positions inside dec_uop_t.instr_type (one-hot)
//   dec_uop_t      : one decoded micro-op
//   dec_bundle_t   : decoded bundle at the default width and 32-bit PCs
//   alu_type       : maps funct3 plus the alternate bit (instr[30]) to an instr_type
package riscv;
  localparam int FRONTEND_WIDTH = 2;
  localparam int T_ADD = 0;
  localparam int T_SUB = 1;
  localparam int T_SLT = 2;
  localparam int T_SLTU = 3;
  localparam int T_XOR = 4;
  localparam int T_OR = 5;
  localparam int T_AND = 6;
  localparam int T_SLL = 7;
  localparam int T_SRL = 8;
  localparam int T_SRA = 9;
  localparam int T_LUI = 10;
  localparam int T_AUIPC = 11;
  localparam int T_JUMP = 12;

  typedef struct packed {
    logic        rd_v;
    logic [4:0]  rd;
    logic        rs1_v;
    logic [4:0]  rs1;
    logic        rs2_v;
    logic [4:0]  rs2;
    logic        rs2_is_immediat;
    logic        is_store;
    logic        is_load;
    logic        is_branch;
    logic [31:0] immediat;
    logic [2:0]  access_size;
    logic [12:0] instr_type;
    logic        unsign_extension;
  } dec_uop_t;

  typedef struct packed {
    logic [FRONTEND_WIDTH-1:0]        lane_v;
    dec_uop_t [FRONTEND_WIDTH-1:0]    uop;
    logic [FRONTEND_WIDTH-1:0][31:0]  pc;
    logic                             exc_v;
    logic [$clog2(FRONTEND_WIDTH)-1:0] exc_lane;
  } dec_bundle_t;

  function automatic logic [12:0] alu_type(input logic [2:0] f3, input logic alt);
    int t;
    t = f3 == 3'd0 ? (alt ? T_SUB : T_ADD) :
        f3 == 3'd1 ? T_SLL :
        f3 == 3'd2 ? T_SLT :
        f3 == 3'd3 ? T_SLTU :
        f3 == 3'd4 ? T_XOR :
        f3 == 3'd5 ? (alt ? T_SRA : T_SRL) :
        f3 == 3'd6 ? T_OR : T_AND;
    return 13'(1) << t;
  endfunction
endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: 2-entry (MAIN/SKID) registered buffer with valid/ready on both sides
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset (zeroes both entries)
//   flush               : drop everything, incoming included
//   in_valid/in_ready   : upstream handshake; in_ready depends on state only
//   in_data             : W-bit payload
//   out_valid/out_ready : downstream handshake
//   out_data            : MAIN entry, held while out_valid & ~out_ready
module dec_skid_buf #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic cap;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data = main_q;
  assign cap = in_valid & in_ready & ~flush;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  always_comb begin
    state_d = state;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) state_d = EMPTY;
    else
      case (state)
        EMPTY: begin
          main_d = cap ? in_data : main_q;
          state_d = cap ? ONE : EMPTY;
        end
        ONE: begin
          main_d = out_ready && cap ? in_data : main_q;
          skid_d = !out_ready && cap ? in_data : skid_q;
          state_d = out_ready ? (cap ? ONE : EMPTY) : (cap ? FULL : ONE);
        end
        FULL: begin
          main_d = out_ready ? skid_q : main_q;
          state_d = out_ready ? ONE : FULL;
        end
        default: state_d = EMPTY;
      endcase
  end
endmodule

// File: rtl/decoder.sv
// decoder: RV32I single-instruction decoder
// Ports:
//   instr   : 32-bit instruction word
//   uop     : decoded micro-op, all-zero when illegal
//   illegal : instruction is not a supported RV32I encoding
module decoder
  import riscv::*;
(
  input  logic [31:0] instr,
  output dec_uop_t    uop,
  output logic        illegal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  always_comb begin
    uop = '0;
    illegal = 1'b0;
    case (op)
      7'h13: begin
        illegal = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        uop.rd_v = 1'b1;
        uop.rs1_v = 1'b1;
        uop.rs2_is_immediat = 1'b1;
        uop.immediat = {{20{instr[31]}}, instr[31:20]};
        uop.instr_type = alu_type(f3, f3 == 3'd5 && instr[30]);
      end
      7'h33: begin
        illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        uop.rd_v = 1'b1;
        uop.rs1_v = 1'b1;
        uop.rs2_v = 1'b1;
        uop.instr_type = alu_type(f3, instr[30]);
      end
      7'h37, 7'h17: begin
        uop.rd_v = 1'b1;
        uop.rs2_is_immediat = 1'b1;
        uop.immediat = {instr[31:12], 12'b0};
        uop.instr_type = 13'(1) << (op[5] ? T_LUI : T_AUIPC);
      end
      7'h6f: begin
        uop.rd_v = 1'b1;
        uop.is_branch = 1'b1;
        uop.immediat = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        uop.instr_type = 13'(1) << T_JUMP;
      end
      7'h67: begin
        illegal = f3 != 3'd0;
        uop.rd_v = 1'b1;
        uop.rs1_v = 1'b1;
        uop.is_branch = 1'b1;
        uop.rs2_is_immediat = 1'b1;
        uop.immediat = {{20{instr[31]}}, instr[31:20]};
        uop.instr_type = 13'(1) << T_JUMP;
      end
      7'h63: begin
        illegal = f3[2:1] == 2'b01;
        uop.rs1_v = 1'b1;
        uop.rs2_v = 1'b1;
        uop.is_branch = 1'b1;
        uop.immediat = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        uop.instr_type = 13'(1) << (f3[2] ? (f3[1] ? T_SLTU : T_SLT) : T_SUB);
        uop.unsign_extension = f3[1];
      end
      7'h03: begin
        illegal = f3[1:0] == 2'b11 || f3 == 3'd6;
        uop.rd_v = 1'b1;
        uop.rs1_v = 1'b1;
        uop.is_load = 1'b1;
        uop.rs2_is_immediat = 1'b1;
        uop.immediat = {{20{instr[31]}}, instr[31:20]};
        uop.instr_type = 13'(1) << T_ADD;
        uop.access_size = {1'b0, f3[1:0]};
        uop.unsign_extension = f3[2];
      end
      7'h23: begin
        illegal = f3[2] || f3[1:0] == 2'b11;
        uop.rs1_v = 1'b1;
        uop.rs2_v = 1'b1;
        uop.is_store = 1'b1;
        uop.immediat = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        uop.instr_type = 13'(1) << T_ADD;
        uop.access_size = {1'b0, f3[1:0]};
      end
      default: illegal = 1'b1;
    endcase
    uop.rd = uop.rd_v ? instr[11:7] : '0;
    uop.rs1 = uop.rs1_v ? instr[19:15] : '0;
    uop.rs2 = uop.rs2_v ? instr[24:20] : '0;
    uop = illegal ? '0 : uop;
  end
endmodule

// File: rtl/dec_stage.sv
// dec_stage: registered multi-lane decode stage with truncation at the first illegal lane
// Ports:
//   clk, reset_n                : clock, synchronous active-low reset
//   flush_i                     : discard buffered and incoming bundles
//   in_valid_i/in_ready_o       : fetch-side handshake
//   in_lane_v_i, in_instr_i     : per-lane valid and instruction words
//   in_pc_i                     : lane 0 PC, lane k = in_pc_i + k*PC_INC
//   out_valid_o/out_ready_i     : rename-side handshake
//   out_lane_v_o, out_uop_o     : per-lane valid and decoded micro-ops
//   out_pc_o                    : per-lane PCs
//   out_exc_v_o, out_exc_lane_o : illegal-instruction flag and lane
// Optional (DEC_PERF_CNT_EN):
//   perf_dec_cnt_o   : micro-ops delivered on output handshakes
//   perf_stall_cnt_o : cycles fetch offered a bundle while in_ready_o=0
module dec_stage
  import riscv::*;
#(
  parameter int NB_LANES = FRONTEND_WIDTH,
  parameter int XLEN = 32,
  parameter int PC_INC = 4,
  localparam int EW = NB_LANES > 1 ? $clog2(NB_LANES) : 1,
  localparam int UW = $bits(dec_uop_t)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NB_LANES-1:0]    in_lane_v_i,
  input  logic [NB_LANES*XLEN-1:0] in_instr_i,
  input  logic [XLEN-1:0]        in_pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NB_LANES-1:0]    out_lane_v_o,
  output logic [NB_LANES*UW-1:0] out_uop_o,
  output logic [NB_LANES*XLEN-1:0] out_pc_o,
  output logic                   out_exc_v_o,
`ifdef DEC_PERF_CNT_EN
  output logic [63:0]            perf_dec_cnt_o,
  output logic [63:0]            perf_stall_cnt_o,
`endif
  output logic [EW-1:0]          out_exc_lane_o
);
  typedef struct packed {
    logic [NB_LANES-1:0]           lane_v;
    dec_uop_t [NB_LANES-1:0]       uop;
    logic [NB_LANES-1:0][XLEN-1:0] pc;
    logic                          exc_v;
    logic [EW-1:0]                 exc_lane;
  } bundle_t;
  dec_uop_t [NB_LANES-1:0] raw, uop_m;
  logic [NB_LANES-1:0][XLEN-1:0] pcs;
  logic [NB_LANES-1:0] ill, bad, keep, lane_v;
  logic [EW-1:0] exc_lane;
  logic seen;
  bundle_t bin, bout;
  for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
    decoder u_dec (
      .instr(in_instr_i[k*XLEN +: 32]),
      .uop(raw[k]),
      .illegal(ill[k])
    );
    assign uop_m[k] = lane_v[k] ? raw[k] : '0;
    assign pcs[k] = in_pc_i + XLEN'(k * PC_INC);
  end
  assign bad = in_lane_v_i & ill;
  // keep[k] is set while no lower lane is a valid illegal one, so the first illegal lane itself survives
  always_comb begin
    keep = '0;
    exc_lane = '0;
    seen = 1'b0;
    for (int k = 0; k < NB_LANES; k++) begin
      keep[k] = ~seen;
      exc_lane = bad[k] && !seen ? EW'(k) : exc_lane;
      seen = seen | bad[k];
    end
  end
  assign lane_v = in_lane_v_i & keep;
  assign bin = '{lane_v: lane_v, uop: uop_m, pc: pcs, exc_v: |bad, exc_lane: exc_lane};
  // bundles with no valid lane never enter the buffer
  dec_skid_buf #(.W($bits(bundle_t))) u_skid (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush_i),
    .in_valid(in_valid_i & |in_lane_v_i),
    .in_ready(in_ready_o),
    .in_data(bin),
    .out_valid(out_valid_o),
    .out_ready(out_ready_i),
    .out_data(bout)
  );
  assign out_lane_v_o = bout.lane_v;
  assign out_uop_o = bout.uop;
  assign out_pc_o = bout.pc;
  assign out_exc_v_o = bout.exc_v;
  assign out_exc_lane_o = bout.exc_lane;
`ifdef DEC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_dec_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      perf_dec_cnt_o <= out_valid_o && out_ready_i ? perf_dec_cnt_o + 64'($countones(out_lane_v_o)) : perf_dec_cnt_o;
      perf_stall_cnt_o <= in_valid_i && !in_ready_o ? perf_stall_cnt_o + 64'd1 : perf_stall_cnt_o;
    end
  end
`endif
endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage: scoreboard bench for dec_stage with directed bundles
module tb_dec_stage;
  import riscv::*;
  localparam int NB = 2;
  localparam int XL = 32;
  localparam int UW = $bits(dec_uop_t);
  localparam int SW = NB + NB * UW + NB * XL + 2;
  localparam logic [31:0] ADDI5 = 32'h00500093;
  localparam logic [31:0] ADD = 32'h00208133;
  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ILL = 32'h00000000;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ri;
    logic [31:0] imm;
  } lane_e;
  typedef struct packed {
    logic [1:0]  lane_v;
    logic        exc_v;
    logic        exc_lane;
    logic [31:0] pc0;
    logic [31:0] pc1;
    lane_e       l0;
    lane_e       l1;
  } exp_t;

  localparam lane_e E_ADDI5 = '{rd: 5'd1, rs1: 5'd0, rs2: 5'd0, ri: 1'b1, imm: 32'd5};
  localparam lane_e E_ADDI1 = '{rd: 5'd1, rs1: 5'd0, rs2: 5'd0, ri: 1'b1, imm: 32'd1};
  localparam lane_e E_ADD = '{rd: 5'd2, rs1: 5'd1, rs2: 5'd2, ri: 1'b0, imm: 32'd0};
  localparam lane_e E_Z = '0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic out_ready_i = 1'b1;
  logic [NB-1:0] in_lane_v_i = '0;
  logic [NB*XL-1:0] in_instr_i = '0;
  logic [XL-1:0] in_pc_i = '0;
  logic in_ready_o, out_valid_o, out_exc_v_o;
  logic [NB-1:0] out_lane_v_o;
  logic [NB*UW-1:0] out_uop_o;
  logic [NB*XL-1:0] out_pc_o;
  logic [0:0] out_exc_lane_o;
`ifdef DEC_PERF_CNT_EN
  logic [63:0] perf_dec_cnt, perf_stall_cnt;
`endif
  logic [SW-1:0] cur, snap;
  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_stage #(.NB_LANES(NB), .XLEN(XL), .PC_INC(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_lane_v_i(in_lane_v_i),
    .in_instr_i(in_instr_i),
    .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_lane_v_o(out_lane_v_o),
    .out_uop_o(out_uop_o),
    .out_pc_o(out_pc_o),
    .out_exc_v_o(out_exc_v_o),
`ifdef DEC_PERF_CNT_EN
    .perf_dec_cnt_o(perf_dec_cnt),
    .perf_stall_cnt_o(perf_stall_cnt),
`endif
    .out_exc_lane_o(out_exc_lane_o)
  );

  assign cur = {out_lane_v_o, out_uop_o, out_pc_o, out_exc_v_o, out_exc_lane_o};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lane_e got(input int k);
    dec_uop_t u;
    u = out_uop_o[k*UW +: UW];
    return '{rd: u.rd, rs1: u.rs1, rs2: u.rs2, ri: u.rs2_is_immediat, imm: u.immediat};
  endfunction

  function automatic exp_t mk(input logic [1:0] lv, input logic xv, input logic xl,
                              input logic [31:0] p0, input logic [31:0] p1, input lane_e a, input lane_e b);
    return '{lane_v: lv, exc_v: xv, exc_lane: xl, pc0: p0, pc1: p1, l0: a, l1: b};
  endfunction

  task automatic drive(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    in_valid_i = 1'b1;
    in_lane_v_i = lv;
    in_instr_i = {i1, i0};
    in_pc_i = pc;
  endtask

  task automatic wait_cap(input string name);
    logic rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = in_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    chk({name, "_accepted"}, 64'(rdy), 64'd1);
  endtask

  task automatic offer(input string name, input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input exp_t e, input logic push);
    drive(lv, i0, i1, pc);
    if (push) q.push_back(e);
    wait_cap(name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid_o && out_ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got pc0 %0h expected no bundle", out_pc_o[31:0]);
        end else begin
          m_e = q.pop_front();
          chk("out_lane_v", 64'(out_lane_v_o), 64'(m_e.lane_v));
          chk("out_exc_v", 64'(out_exc_v_o), 64'(m_e.exc_v));
          chk("out_exc_lane", 64'(out_exc_lane_o), 64'(m_e.exc_lane));
          chk("out_pc", 64'(out_pc_o), {m_e.pc1, m_e.pc0});
          chk("uop_lane0", 64'(got(0)), 64'(m_e.l0));
          chk("uop_lane1", 64'(got(1)), 64'(m_e.l1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_lane_v", 64'(out_lane_v_o), 64'd0);
    chk("rst_exc_v", 64'(out_exc_v_o), 64'd0);
    chk("rst_exc_lane", 64'(out_exc_lane_o), 64'd0);
    chk("rst_uop_zero", 64'(|out_uop_o), 64'd0);
    chk("rst_pc", 64'(out_pc_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);

    offer("first", 2'b11, ADDI5, ADD, 32'h1000, mk(2'b11, 1'b0, 1'b0, 32'h1000, 32'h1004, E_ADDI5, E_ADD), 1'b1);
    chk("first_latency", 64'(out_valid_o), 64'd1);
    offer("ill_lane0", 2'b11, ILL, ADDI1, 32'h2000, mk(2'b01, 1'b1, 1'b0, 32'h2000, 32'h2004, E_Z, E_Z), 1'b1);
    offer("ill_lane1", 2'b11, ADDI1, ILL, 32'h3000, mk(2'b11, 1'b1, 1'b1, 32'h3000, 32'h3004, E_ADDI1, E_Z), 1'b1);
    offer("all_invalid", 2'b00, ADD, ADD, 32'h4000, '0, 1'b0);
    chk("drop_out_valid", 64'(out_valid_o), 64'd0);
    offer("hole_wrap", 2'b10, ADDI5, ADD, 32'hFFFFFFFC, mk(2'b10, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000000, E_Z, E_ADD), 1'b1);
    idle(2);

    out_ready_i = 1'b0;
    offer("bp1", 2'b11, ADDI1, ADD, 32'h6000, mk(2'b11, 1'b0, 1'b0, 32'h6000, 32'h6004, E_ADDI1, E_ADD), 1'b1);
    offer("bp2", 2'b01, ADD, ADDI5, 32'h7000, mk(2'b01, 1'b0, 1'b0, 32'h7000, 32'h7004, E_ADD, E_Z), 1'b1);
    chk("bp_in_ready_full", 64'(in_ready_o), 64'd0);
    drive(2'b11, ADDI5, ADDI1, 32'h8000);
    q.push_back(mk(2'b11, 1'b0, 1'b0, 32'h8000, 32'h8004, E_ADDI5, E_ADDI1));
    snap = cur;
    idle(3);
    chk("bp_hold_pc", 64'(out_pc_o), {32'h6004, 32'h6000});
    chk("bp_hold_stable", 64'(cur == snap), 64'd1);
    chk("bp_stall_ready", 64'(in_ready_o), 64'd0);
    out_ready_i = 1'b1;
    wait_cap("bp3");
    idle(3);

    out_ready_i = 1'b0;
    offer("fl1", 2'b11, ADDI5, ADD, 32'h9000, '0, 1'b0);
    offer("fl2", 2'b11, ADD, ADDI5, 32'hA000, '0, 1'b0);
    chk("fl_full", 64'(in_ready_o), 64'd0);
    drive(2'b11, ADDI1, ADDI1, 32'hB000);
    flush_i = 1'b1;
    idle(1);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("fl_out_valid", 64'(out_valid_o), 64'd0);
    chk("fl_in_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    idle(4);

    out_ready_i = 1'b0;
    offer("mid1", 2'b11, ILL, ADD, 32'hC000, '0, 1'b0);
    chk("mid_exc_before", 64'(out_exc_v_o), 64'd1);
    reset_n = 1'b0;
    idle(1);
    chk("mid_out_valid", 64'(out_valid_o), 64'd0);
    chk("mid_lane_v", 64'(out_lane_v_o), 64'd0);
    chk("mid_exc_v", 64'(out_exc_v_o), 64'd0);
    chk("mid_uop_zero", 64'(|out_uop_o), 64'd0);
    chk("mid_pc", 64'(out_pc_o), 64'd0);
    reset_n = 1'b1;
    out_ready_i = 1'b1;
    offer("after_rst", 2'b11, ADD, ADDI5, 32'hD000, mk(2'b11, 1'b0, 1'b0, 32'hD000, 32'hD004, E_ADD, E_ADDI5), 1'b1);
    idle(3);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
